// File: rtl/draw_sprite_blit.sv
// Sprite blitter: copies an SPR_W x SPR_H sprite from ROM into the frame buffer with
// colour-key transparency, flips and screen-edge clipping, one pixel per ROM read.
module draw_sprite_blit #(
   parameter int               SPR_W  = 8,
   parameter int               SPR_H  = 8,
   parameter int               SCR_W  = 640,
   parameter int               SCR_H  = 480,
   parameter int               PIX_W  = 24,
   parameter int               ROM_AW = 14,
   parameter int               FB_AW  = 19,
   parameter int               IMG_W  = 8,
   parameter logic [PIX_W-1:0] KEY    = 24'hFF00FF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [IMG_W-1:0]  img_sel,
   input  logic [9:0]        x_pos,
   input  logic [8:0]        y_pos,
   input  logic              flip_h,
   input  logic              flip_v,
   output logic              busy,
   output logic              done,
   output logic              rom_rd_en,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [31:0]       rom_data,
   input  logic              rom_data_valid,
   output logic              fb_we,
   output logic [FB_AW-1:0]  fb_addr,
   output logic [PIX_W-1:0]  fb_data,
   input  logic              fb_ready
);

   localparam int CW = $clog2(SPR_W);
   localparam int RW = $clog2(SPR_H);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_NEXT, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [IMG_W-1:0]   img_q, img_d;
   logic [9:0]         x_q, x_d;
   logic [8:0]         y_q, y_d;
   logic               fh_q, fh_d, fv_q, fv_d;
   logic [RW-1:0]      row_q, row_d;
   logic [CW-1:0]      col_q, col_d;
   logic               busy_q, busy_d, done_q, done_d, rom_rd_en_q, rom_rd_en_d, fb_we_q, fb_we_d;
   logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
   logic [FB_AW-1:0]   fb_addr_q, fb_addr_d;
   logic [PIX_W-1:0]   fb_data_q, fb_data_d;

   logic [PIX_W-1:0]   pix;
   logic [10:0]        dx;
   logic [9:0]         dy;
   logic [31:0]        fb_full;
   logic [CW-1:0]      col_inc;
   logic [RW-1:0]      row_inc;

   // Flip only changes which source pixel is fetched; destination stays in raster order.
   function automatic logic [ROM_AW-1:0] src_addr(input logic [IMG_W-1:0] img, input logic fh,
                                                  input logic fv, input logic [RW-1:0] r,
                                                  input logic [CW-1:0] c);
      logic [CW-1:0] sc;
      logic [RW-1:0] sr;
      logic [31:0]   a;
      sc = fh ? CW'(SPR_W - 1) - c : c;
      sr = fv ? RW'(SPR_H - 1) - r : r;
      a  = 32'(img) * 32'(SPR_W * SPR_H) + 32'(sr) * 32'(SPR_W) + 32'(sc);
      return a[ROM_AW-1:0];
   endfunction

   always_comb begin
      state_d     = state_q;
      img_d       = img_q;
      x_d         = x_q;
      y_d         = y_q;
      fh_d        = fh_q;
      fv_d        = fv_q;
      row_d       = row_q;
      col_d       = col_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      rom_rd_en_d = 1'b0;
      rom_addr_d  = rom_addr_q;
      fb_we_d     = fb_we_q;
      fb_addr_d   = fb_addr_q;
      fb_data_d   = fb_data_q;
      pix         = rom_data[PIX_W-1:0];
      dx          = 11'(x_q) + 11'(col_q);
      dy          = 10'(y_q) + 10'(row_q);
      fb_full     = 32'(dy) * 32'(SCR_W) + 32'(dx);
      col_inc     = col_q + CW'(1);
      row_inc     = row_q + RW'(1);
      case (state_q)
         S_IDLE: if (start) begin
            img_d       = img_sel;
            x_d         = x_pos;
            y_d         = y_pos;
            fh_d        = flip_h;
            fv_d        = flip_v;
            row_d       = '0;
            col_d       = '0;
            busy_d      = 1'b1;
            rom_rd_en_d = 1'b1;
            rom_addr_d  = src_addr(img_sel, flip_h, flip_v, '0, '0);
            state_d     = S_READ;
         end
         S_READ: state_d = S_WAIT;
         S_WAIT: if (rom_data_valid) begin
            if (pix == KEY || dx >= 11'(SCR_W) || dy >= 10'(SCR_H)) begin
               state_d = S_NEXT;
            end else begin
               fb_we_d   = 1'b1;
               fb_addr_d = fb_full[FB_AW-1:0];
               fb_data_d = pix;
               state_d   = S_WRITE;
            end
         end
         S_WRITE: if (fb_ready) begin
            fb_we_d = 1'b0;
            state_d = S_NEXT;
         end
         S_NEXT: begin
            if (col_q == CW'(SPR_W - 1) && row_q == RW'(SPR_H - 1)) begin
               col_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               if (col_q == CW'(SPR_W - 1)) begin
                  col_d = '0;
                  row_d = row_inc;
               end else begin
                  col_d = col_inc;
               end
               rom_rd_en_d = 1'b1;
               rom_addr_d  = src_addr(img_q, fh_q, fv_q, row_d, col_d);
               state_d     = S_READ;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         img_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         fh_q        <= 1'b0;
         fv_q        <= 1'b0;
         row_q       <= '0;
         col_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rom_rd_en_q <= 1'b0;
         rom_addr_q  <= '0;
         fb_we_q     <= 1'b0;
         fb_addr_q   <= '0;
         fb_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         img_q       <= img_d;
         x_q         <= x_d;
         y_q         <= y_d;
         fh_q        <= fh_d;
         fv_q        <= fv_d;
         row_q       <= row_d;
         col_q       <= col_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         rom_rd_en_q <= rom_rd_en_d;
         rom_addr_q  <= rom_addr_d;
         fb_we_q     <= fb_we_d;
         fb_addr_q   <= fb_addr_d;
         fb_data_q   <= fb_data_d;
      end
   end

   generate
      if (PIX_W < 32) begin : g_rom_hi
         logic unused_rom_hi;
         assign unused_rom_hi = ^rom_data[31:PIX_W];
      end
   endgenerate

   assign busy      = busy_q;
   assign done      = done_q;
   assign rom_rd_en = rom_rd_en_q;
   assign rom_addr  = rom_addr_q;
   assign fb_we     = fb_we_q;
   assign fb_addr   = fb_addr_q;
   assign fb_data   = fb_data_q;

endmodule

// File: tb/tb_draw_sprite_blit.sv
// Directed bench for draw_sprite_blit: ROM responder, frame-buffer ready driver and write monitor.
module tb_draw_sprite_blit;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        start = 1'b0, flip_h = 1'b0, flip_v = 1'b0;
   logic [7:0]  img_sel = '0;
   logic [9:0]  x_pos = '0;
   logic [8:0]  y_pos = '0;
   logic        busy, done, rom_rd_en, fb_we;
   logic [13:0] rom_addr;
   logic [31:0] rom_data = '0;
   logic        rom_data_valid = 1'b0;
   logic [18:0] fb_addr;
   logic [23:0] fb_data;
   logic        fb_ready = 1'b1;

   localparam logic [23:0] KEYV = 24'hFF00FF;

   draw_sprite_blit dut (
      .clk(clk), .rst_n(rst_n), .start(start), .img_sel(img_sel), .x_pos(x_pos), .y_pos(y_pos),
      .flip_h(flip_h), .flip_v(flip_v), .busy(busy), .done(done), .rom_rd_en(rom_rd_en),
      .rom_addr(rom_addr), .rom_data(rom_data), .rom_data_valid(rom_data_valid), .fb_we(fb_we),
      .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int rd_count, done_count, stall_cycles, first_rd, rom_lat = 0, stall_left = 0;
   bit key_even = 0, stall_mode = 0, pend = 0, was_stalled = 0;
   int pend_wait;
   logic [13:0] pend_addr;
   logic [18:0] last_addr;
   logic [23:0] last_data;
   logic [63:0] wr_q[$], exp_q[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] rom_pix(input logic [13:0] a);
      return (key_even && !a[0]) ? KEYV : {10'd0, a};
   endfunction

   // ROM: answers each read rom_lat cycles after the read cycle, upper byte is junk.
   initial forever begin
      @(posedge clk); #1;
      rom_data_valid = 1'b0;
      if (!rst_n) pend = 0;
      if (pend) begin
         if (pend_wait == 0) begin
            rom_data_valid = 1'b1;
            rom_data = {8'h5A, rom_pix(pend_addr)};
            pend = 0;
         end else pend_wait--;
      end
      if (rst_n && rom_rd_en) begin
         pend = 1; pend_wait = rom_lat; pend_addr = rom_addr;
      end
   end

   initial forever begin
      @(posedge clk); #1;
      if (stall_mode && fb_we && wr_q.size() == 2 && stall_left > 0) begin
         fb_ready = 1'b0; stall_left--;
      end else fb_ready = 1'b1;
   end

   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (rom_rd_en) begin
            if (rd_count == 0) first_rd = int'(rom_addr);
            rd_count++;
         end
         if (done) done_count++;
         if (fb_we && !fb_ready) begin
            if (was_stalled) begin
               chk("stall_addr", fb_addr, last_addr);
               chk("stall_data", fb_data, last_data);
            end
            stall_cycles++;
            was_stalled = 1;
         end else was_stalled = 0;
         if (fb_we && fb_ready) wr_q.push_back({13'd0, fb_addr, 8'd0, fb_data});
         last_addr = fb_addr;
         last_data = fb_data;
      end
   end

   task automatic build_exp(input int img, input int x, input int y, input bit fh, input bit fv);
      exp_q.delete();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            int sc, sr, a;
            logic [23:0] d;
            sc = fh ? 7 - c : c;
            sr = fv ? 7 - r : r;
            a  = (img * 64 + sr * 8 + sc) % 16384;
            d  = rom_pix(14'(a));
            if (d != KEYV && x + c < 640 && y + r < 480)
               exp_q.push_back({13'd0, 19'((y + r) * 640 + x + c), 8'd0, d});
         end
   endtask

   task automatic cmp_writes(input string tag);
      int n;
      chk({tag, "_nwr"}, wr_q.size(), exp_q.size());
      n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk($sformatf("%s_w%0d", tag, i), wr_q[i], exp_q[i]);
   endtask

   task automatic clear_mon();
      wr_q.delete(); rd_count = 0; done_count = 0; stall_cycles = 0; first_rd = -1;
   endtask

   task automatic run_draw(input logic [7:0] img, input logic [9:0] x, input logic [8:0] y,
                           input bit fh, input bit fv, input bit poke, output int cyc);
      clear_mon();
      @(posedge clk); #1;
      start = 1'b1; img_sel = img; x_pos = x; y_pos = y; flip_h = fh; flip_v = fv;
      @(posedge clk); cyc = 1; #1;
      start = 1'b0;
      chk("busy_after_start", busy, 1'b1);
      while (!done && cyc < 3000) begin
         if (poke && cyc inside {[10:12]}) begin
            start = 1'b1; img_sel = img + 8'd5; x_pos = 10'd3; flip_h = ~fh;
         end else start = 1'b0;
         @(posedge clk); #1; cyc++;
      end
      start = 1'b0;
      chk("busy_at_done", busy, 1'b0);
      @(posedge clk); #1;
      chk("done_one_cycle", done, 1'b0);
      chk("done_count", done_count, 1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ctl"}, {busy, done, rom_rd_en, fb_we}, 4'b0);
      chk({tag, "_rom_addr"}, rom_addr, 0);
      chk({tag, "_fb_addr"}, fb_addr, 0);
      chk({tag, "_fb_data"}, fb_data, 0);
   endtask

   initial begin
      int cyc, mx, guard;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst_n = 1'b1;

      // Plain draw at origin
      build_exp(0, 0, 0, 0, 0);
      run_draw(8'd0, 10'd0, 9'd0, 0, 0, 0, cyc);
      chk("t1_latency", cyc, 257);
      chk("t1_reads", rd_count, 64);
      cmp_writes("t1");
      chk("t1_first", (wr_q.size() > 0) ? wr_q[0] : '1, {13'd0, 19'd0, 8'd0, 24'd0});
      chk("t1_last", (wr_q.size() == 64) ? wr_q[63] : '1, {13'd0, 19'd4487, 8'd0, 24'd63});

      // Horizontal flip, image 3
      build_exp(3, 100, 50, 1, 0);
      run_draw(8'd3, 10'd100, 9'd50, 1, 0, 0, cyc);
      chk("t2_first_rd", first_rd, 199);
      chk("t2_first_wr", (wr_q.size() > 0) ? wr_q[0] : '1, {13'd0, 19'd32100, 8'd0, 24'd199});
      chk("t2_latency", cyc, 257);
      cmp_writes("t2");

      // Colour key on even source addresses
      key_even = 1;
      build_exp(0, 0, 0, 0, 0);
      run_draw(8'd0, 10'd0, 9'd0, 0, 0, 0, cyc);
      chk("t3_nwr", wr_q.size(), 32);
      chk("t3_latency", cyc, 225);
      cmp_writes("t3");
      key_even = 0;

      // Bottom-right corner clipping
      build_exp(0, 636, 476, 0, 0);
      run_draw(8'd0, 10'd636, 9'd476, 0, 0, 0, cyc);
      mx = 0;
      foreach (wr_q[i]) if (int'(wr_q[i][50:32]) > mx) mx = int'(wr_q[i][50:32]);
      chk("t4_nwr", wr_q.size(), 16);
      chk("t4_max_addr", mx, 307199);
      chk("t4_latency", cyc, 209);
      cmp_writes("t4");

      // Slow ROM and a stalled third write
      rom_lat = 3; stall_mode = 1; stall_left = 5;
      build_exp(0, 0, 0, 0, 0);
      run_draw(8'd0, 10'd0, 9'd0, 0, 0, 0, cyc);
      chk("t5_reads", rd_count, 64);
      chk("t5_stall_cycles", stall_cycles, 5);
      chk("t5_latency", cyc, 454);
      cmp_writes("t5");
      rom_lat = 0; stall_mode = 0;

      // Reset mid-draw at pixel 20, then a fresh draw with start pokes while busy
      clear_mon();
      @(posedge clk); #1;
      start = 1'b1; img_sel = 8'd1; x_pos = 10'd0; y_pos = 9'd0; flip_h = 0; flip_v = 0;
      @(posedge clk); #1;
      start = 1'b0;
      guard = 0;
      while (wr_q.size() < 20 && guard < 2000) begin
         @(posedge clk); #1; guard++;
      end
      chk("t6_reach_pixel20", wr_q.size(), 20);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("t6_midreset");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("t6_no_done", done_count, 0);
      build_exp(2, 20, 30, 0, 1);
      run_draw(8'd2, 10'd20, 9'd30, 0, 1, 1, cyc);
      chk("t6_latency", cyc, 257);
      chk("t6_reads", rd_count, 64);
      cmp_writes("t6");
      chk("t6_idle_after", busy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/draw_sprite_blit.md
Name: draw_sprite_blit

Overview:
- Parametrised sprite blitter; successor to the fixed 8x8 sprite drawer in the graphics path.
- On start, reads an SPR_W x SPR_H sprite from sprite ROM, one pixel per read, and writes its pixels into the frame buffer at (x_pos, y_pos).
- Adds colour-key transparency, horizontal/vertical flip, screen-edge clipping, and ready/valid handshakes on both memory sides.
- Sits between the game-logic sequencer and the frame-buffer write arbiter.

Parameters:
- SPR_W, 8, sprite width in pixels (power of 2).
- SPR_H, 8, sprite height in pixels (power of 2).
- SCR_W, 640, screen width in pixels.
- SCR_H, 480, screen height in pixels.
- PIX_W, 24, pixel width, RGB888.
- ROM_AW, 14, sprite ROM address width.
- FB_AW, 19, frame-buffer address width.
- IMG_W, 8, image-select width.
- KEY, 24'hFF00FF, transparent colour key.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a draw; sampled only in IDLE
- img_sel  in  IMG_W  sprite index
- x_pos  in  10  left column of the sprite on screen
- y_pos  in  9  top row of the sprite on screen
- flip_h  in  1  mirror the sprite left-right
- flip_v  in  1  mirror the sprite top-bottom
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- rom_rd_en  out  1  one-cycle read request
- rom_addr  out  ROM_AW  sprite pixel address
- rom_data  in  32  read data; bits [PIX_W-1:0] are the pixel
- rom_data_valid  in  1  rom_data is valid this cycle
- fb_we  out  1  frame-buffer write request
- fb_addr  out  FB_AW  frame-buffer pixel address
- fb_data  out  PIX_W  pixel to write
- fb_ready  in  1  write is accepted when fb_we && fb_ready

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - busy, done, rom_rd_en and fb_we are 0.
  - rom_addr, fb_addr, fb_data and the row/column counters are 0.
  - Reset asserted mid-draw aborts the draw immediately; no done pulse is produced.
- Start:
  - In IDLE, start=1 latches img_sel, x_pos, y_pos, flip_h and flip_v.
  - row and col are cleared; the block enters READ.
  - start is ignored in every other state.
- Source coordinates:
  - sc = flip_h ? SPR_W-1-col : col.
  - sr = flip_v ? SPR_H-1-row : row.
  - rom_addr = img_sel*SPR_W*SPR_H + sr*SPR_W + sc, truncated to ROM_AW.
- States:
  - READ: rom_rd_en=1 for exactly one cycle with rom_addr driven; go to WAIT.
  - WAIT: hold rom_addr and wait any number of cycles for rom_data_valid. Only one read is outstanding at a time; rom_data_valid outside WAIT is ignored. On valid, capture pixel = rom_data[PIX_W-1:0] and evaluate it:
    - If pixel == KEY, or dx = x_pos+col >= SCR_W, or dy = y_pos+row >= SCR_H, skip to NEXT with no write.
    - Otherwise go to WRITE.
  - WRITE:
    - fb_we=1, fb_addr = dy*SCR_W + dx, fb_data = pixel.
    - All three are held stable until fb_ready=1. On fb_ready=1, fb_we drops the next cycle; go to NEXT.
    - fb_ready already high on entry completes the write in one cycle.
  - NEXT:
    - col increments. At col == SPR_W-1, col wraps to 0 and row increments.
    - At row == SPR_H-1 with col == SPR_W-1, go to DONE; otherwise go to READ.
  - DONE: done=1 and busy=0 for one cycle; go to IDLE. A new start is accepted no earlier than the next cycle.
- Arithmetic:
  - dx and dy are computed at 11 bits and 10 bits so clipping comparisons never overflow.
  - fb_addr is computed at full width, then truncated to FB_AW.
- Traversal and timing:
  - Pixels are visited in raster order of destination (row, col); the flip affects only the source address.
  - Minimum pixel cost is 4 cycles (READ, WAIT with valid, WRITE, NEXT); a skipped pixel costs 3.
  - With zero-latency ROM and fb_ready tied high, start-to-done latency is 4*SPR_W*SPR_H + 1 cycles minus 1 per skipped pixel.

Test Plan:
- Reset, then start with img_sel=0, x=0, y=0, fb_ready=1, ROM returning rom_addr as data next cycle -> 64 writes at fb_addr 0..7, 640..647, … 4480..4487; done pulses once after 257 cycles.
- img_sel=3, x=100, y=50, flip_h=1 -> first read addr 199 (192+7); first write addr 32100 with that pixel.
- ROM returns 24'hFF00FF for even addresses -> exactly 32 writes, no write to any even-source pixel; done still pulses.
- x=636, y=476, flip off -> only 4x4=16 writes, highest address 479*640+639=307199; no write at dx>=640.
- fb_ready low for 5 cycles on the 3rd write, rom_data_valid delayed 3 cycles -> fb_addr/fb_data stable while stalled; no extra rom_rd_en; total writes still 64.
- Assert rst_n=0 mid-draw at pixel 20, then start again -> outputs 0 immediately; fresh draw completes normally; start pulses while busy are ignored.
